// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_pkg
// Purpose  : Shared constants for the shift arbiter: datapath width, shift
//            amount width and the 2-bit operation encodings.
// Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

   localparam int XLEN    = 32;
   localparam int SHAMT_W = 5;

   localparam logic [1:0] SH_SLL = 2'b00;
   localparam logic [1:0] SH_SRL = 2'b01;
   localparam logic [1:0] SH_SRA = 2'b10;
   localparam logic [1:0] SH_RSV = 2'b11;

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter_if
// Purpose  : Bundles the two request ports and the result port of the shift
//            arbiter. The slave modport is the arbiter's view; the master
//            modport is the view of the requesters and result consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_arbiter_if #(
   parameter int XLEN  = shift_pkg::XLEN,
   parameter int TAG_W = 4
);

   logic             req0_valid;
   logic             req0_ready;
   logic [1:0]       req0_op;
   logic [XLEN-1:0]  req0_a;
   logic [XLEN-1:0]  req0_b;
   logic [TAG_W-1:0] req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [1:0]       req1_op;
   logic [XLEN-1:0]  req1_a;
   logic [XLEN-1:0]  req1_b;
   logic [TAG_W-1:0] req1_tag;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_result;
   logic             out_src;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
      input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
      input  out_ready,
      output req0_ready, req1_ready,
      output out_valid, out_result, out_src, out_tag
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_tag,
      output req1_valid, req1_op, req1_a, req1_b, req1_tag,
      output out_ready,
      input  req0_ready, req1_ready,
      input  out_valid, out_result, out_src, out_tag
   );

endinterface
`default_nettype wire

// File: rtl/shift_core.sv
`default_nettype none
// ============================================================================
// Module   : shift_core
// Purpose  : Purely combinational 32-bit shifter: SLL, SRL, SRA, and a
//            pass-through for the reserved encoding.
// Revision : 1.0 - initial release
// ============================================================================
module shift_core
   import shift_pkg::*;
(
   input  wire logic [XLEN-1:0]    i_a,
   input  wire logic [SHAMT_W-1:0] i_shamt,
   input  wire logic [1:0]         i_op,
   output logic      [XLEN-1:0]    o_result
);

   // Select the shift flavour; reserved op and any unknown code pass a through
   always_comb begin
      o_result = i_a;
      case (i_op)
         SH_SLL:  o_result = i_a << i_shamt;
         SH_SRL:  o_result = i_a >> i_shamt;
         SH_SRA:  o_result = $signed(i_a) >>> i_shamt;
         default: o_result = i_a;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : shift_arbiter
// Purpose  : Two-port round-robin arbiter in front of a shared shifter with a
//            single registered result stage (1-cycle latency, full throughput).
// Revision : 1.0 - initial release
// ============================================================================
module shift_arbiter #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  wire logic       clk_in,
   input  wire logic       rst_in,
   input  wire logic       rdy_in,
   shift_arbiter_if.slave  bus
);

   import shift_pkg::*;

   logic                w_can_accept;
   logic                w_grant0;
   logic                w_grant1;
   logic                w_accept;
   logic                w_sel;
   logic [1:0]          w_op;
   logic [XLEN-1:0]     w_a;
   logic [SHAMT_W-1:0]  w_shamt;
   logic [TAG_W-1:0]    w_tag;
   logic [XLEN-1:0]     w_result;

   logic                r_prio;
   logic                r_out_valid;
   logic [XLEN-1:0]     r_out_result;
   logic                r_out_src;
   logic [TAG_W-1:0]    r_out_tag;

   // The result register can take a new entry when it is empty or being
   // drained this cycle; reset suppresses every ready.
   assign w_can_accept = ~rst_in & rdy_in & (~r_out_valid | bus.out_ready);

   // Favoured port wins a tie; a lone requester always wins
   assign w_grant0 = bus.req0_valid & (~bus.req1_valid | ~r_prio);
   assign w_grant1 = bus.req1_valid & (~bus.req0_valid |  r_prio);

   assign bus.req0_ready = w_can_accept & w_grant0;
   assign bus.req1_ready = w_can_accept & w_grant1;

   assign w_accept = bus.req0_ready | bus.req1_ready;
   assign w_sel    = bus.req1_ready;

   // Only the low shift-amount bits reach the shifter; the rest are ignored
   assign w_op    = w_sel ? bus.req1_op  : bus.req0_op;
   assign w_a     = w_sel ? bus.req1_a   : bus.req0_a;
   assign w_shamt = w_sel ? bus.req1_b[SHAMT_W-1:0] : bus.req0_b[SHAMT_W-1:0];
   assign w_tag   = w_sel ? bus.req1_tag : bus.req0_tag;

   shift_core u_core (
      .i_a      (w_a),
      .i_shamt  (w_shamt),
      .i_op     (w_op),
      .o_result (w_result)
   );

   // Result register and round-robin pointer; accept overrides drain so a
   // simultaneous drain+accept replaces the entry without a bubble
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_prio       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_src    <= 1'b0;
         r_out_tag    <= '0;
      end else if (w_accept) begin
         r_prio       <= ~w_sel;
         r_out_valid  <= 1'b1;
         r_out_result <= w_result;
         r_out_src    <= w_sel;
         r_out_tag    <= w_tag;
      end else if (rdy_in & r_out_valid & bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_src    = r_out_src;
   assign bus.out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_arbiter
// Purpose  : Self-checking bench for shift_arbiter: table of single requests,
//            scoreboarded contention/backpressure runs, reset and stall cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

   import shift_pkg::*;

   localparam int TW = 4;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   int errors = 0;
   int checks = 0;

   shift_arbiter_if #(.XLEN(32), .TAG_W(TW)) bus ();

   shift_arbiter #(.XLEN(32), .TAG_W(TW)) dut (
      .clk_in (clk),
      .rst_in (rst),
      .rdy_in (rdy),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   result;
      logic          src;
      logic [TW-1:0] tag;
   } exp_t;

   typedef struct {
      int            port;
      logic [1:0]    op;
      logic [31:0]   a;
      logic [31:0]   b;
      logic [TW-1:0] tag;
      logic [31:0]   res;
   } vec_t;

   exp_t sbq[$];
   bit   sb_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Bit-serial reference shifter
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [31:0] r;
      r = a;
      for (int i = 0; i < int'(b[4:0]); i++) begin
         case (op)
            2'b00:   r = {r[30:0], 1'b0};
            2'b01:   r = {1'b0, r[31:1]};
            2'b10:   r = {r[31], r[31:1]};
            default: r = r;
         endcase
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int port, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TW-1:0] tag);
      if (port == 0) begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a;
         bus.req0_b = b; bus.req0_tag = tag;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a;
         bus.req1_b = b; bus.req1_tag = tag;
      end
   endtask

   task automatic idle();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   // Scoreboard: pop on a draining result, push on each accepted request
   always @(negedge clk) begin
      exp_t e;
      if (sb_en) begin
         check("one_ready", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
         if (bus.out_valid && bus.out_ready && rdy && !rst) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got result 0x%08h with empty queue", bus.out_result);
            end else begin
               e = sbq.pop_front();
               check("sb_result", bus.out_result, e.result);
               check("sb_src", {31'd0, bus.out_src}, {31'd0, e.src});
               check("sb_tag", {28'd0, bus.out_tag}, {28'd0, e.tag});
            end
         end
         if (bus.req0_ready)
            sbq.push_back('{model(bus.req0_op, bus.req0_a, bus.req0_b), 1'b0, bus.req0_tag});
         if (bus.req1_ready)
            sbq.push_back('{model(bus.req1_op, bus.req1_a, bus.req1_b), 1'b1, bus.req1_tag});
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[11];
      tbl[0]  = '{0, SH_SRA, 32'h8000_0000, 32'h0000_0004, 4'h3, 32'hF800_0000};
      tbl[1]  = '{1, SH_SRL, 32'hFFFF_FFFF, 32'h0000_0021, 4'h5, 32'h7FFF_FFFF};
      tbl[2]  = '{0, SH_SLL, 32'h0000_0001, 32'h0000_001F, 4'h7, 32'h8000_0000};
      tbl[3]  = '{1, SH_RSV, 32'h0000_1234, 32'h0000_0007, 4'h9, 32'h0000_1234};
      tbl[4]  = '{0, SH_SRA, 32'h4000_0000, 32'hFFFF_FFE3, 4'hA, 32'h0800_0000};
      tbl[5]  = '{1, SH_SLL, 32'hDEAD_BEEF, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF};
      tbl[6]  = '{0, SH_SRL, 32'hDEAD_BEEF, 32'h0000_0020, 4'h1, 32'hDEAD_BEEF};
      tbl[7]  = '{1, SH_SRA, 32'h8000_0001, 32'hFFFF_FFE0, 4'h2, 32'h8000_0001};
      tbl[8]  = '{0, SH_SLL, 32'h0000_00FF, 32'h0000_0008, 4'h4, 32'h0000_FF00};
      tbl[9]  = '{1, SH_SRA, 32'hF000_0000, 32'h0000_001F, 4'h6, 32'hFFFF_FFFF};
      tbl[10] = '{0, SH_SRL, 32'h8000_0000, 32'h0000_001F, 4'h8, 32'h0000_0001};

      rst = 1'b1;
      rdy = 1'b1;
      bus.out_ready = 1'b1;
      bus.req0_op = 2'b00; bus.req0_a = '0; bus.req0_b = '0; bus.req0_tag = '0;
      bus.req1_op = 2'b00; bus.req1_a = '0; bus.req1_b = '0; bus.req1_tag = '0;
      idle();
      set_req(0, SH_SLL, 32'h1, 32'h1, 4'h1);
      set_req(1, SH_SLL, 32'h1, 32'h1, 4'h1);

      // Reset state, and no readies while reset is asserted
      tick();
      @(negedge clk);
      check("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_result", bus.out_result, 32'd0);
      check("rst_out_src", {31'd0, bus.out_src}, 32'd0);
      check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
      tick();
      rst = 1'b0;
      idle();

      // Table of isolated single requests
      for (int i = 0; i < 11; i++) begin
         tick();
         set_req(tbl[i].port, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag);
         @(negedge clk);
         check($sformatf("tbl%0d_ready0", i), {31'd0, bus.req0_ready},
               (tbl[i].port == 0) ? 32'd1 : 32'd0);
         check($sformatf("tbl%0d_ready1", i), {31'd0, bus.req1_ready},
               (tbl[i].port == 1) ? 32'd1 : 32'd0);
         tick();
         idle();
         @(negedge clk);
         check($sformatf("tbl%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("tbl%0d_result", i), bus.out_result, tbl[i].res);
         check($sformatf("tbl%0d_src", i), {31'd0, bus.out_src}, tbl[i].port[31:0]);
         check($sformatf("tbl%0d_tag", i), {28'd0, bus.out_tag}, {28'd0, tbl[i].tag});
         tick();
         @(negedge clk);
         check($sformatf("tbl%0d_drained", i), {31'd0, bus.out_valid}, 32'd0);
      end

      // Contention after reset: grants alternate starting at port 0
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         set_req(0, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom));
         set_req(1, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom));
         @(negedge clk);
         check($sformatf("cont%0d_ready0", k), {31'd0, bus.req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
         check($sformatf("cont%0d_ready1", k), {31'd0, bus.req1_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
         if (k > 0) check($sformatf("cont%0d_valid", k), {31'd0, bus.out_valid}, 32'd1);
      end
      tick();
      idle();
      @(negedge clk);

      // Backpressure: hold result for 3 cycles, then drain and accept together
      tick();
      bus.out_ready = 1'b0;
      set_req(0, SH_SLL, 32'h0000_0003, 32'h0000_0002, 4'hC);
      @(negedge clk);
      check("bp_first_ready0", {31'd0, bus.req0_ready}, 32'd1);
      tick();
      idle();
      set_req(1, SH_SRL, 32'h0000_0100, 32'h0000_0004, 4'hD);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         check($sformatf("bp%0d_ready0", j), {31'd0, bus.req0_ready}, 32'd0);
         check($sformatf("bp%0d_ready1", j), {31'd0, bus.req1_ready}, 32'd0);
         check($sformatf("bp%0d_valid", j), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("bp%0d_result", j), bus.out_result, 32'h0000_000C);
         check($sformatf("bp%0d_src", j), {31'd0, bus.out_src}, 32'd0);
         check($sformatf("bp%0d_tag", j), {28'd0, bus.out_tag}, 32'hC);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready1", {31'd0, bus.req1_ready}, 32'd1);
      tick();
      idle();
      @(negedge clk);
      check("bp_second_src", {31'd0, bus.out_src}, 32'd1);
      tick();
      @(negedge clk);
      check("bp_drained", {31'd0, bus.out_valid}, 32'd0);
      check("sb_empty", sbq.size(), 32'd0);
      sb_en = 1'b0;

      // Reset mid-operation with a pending result and prio pointing at port 1
      tick();
      bus.out_ready = 1'b0;
      set_req(0, SH_SLL, 32'h0000_0001, 32'h0000_0004, 4'h5);
      @(negedge clk);
      check("mid_ready0", {31'd0, bus.req0_ready}, 32'd1);
      tick();
      rst = 1'b1;
      set_req(1, SH_SLL, 32'h0000_0002, 32'h0000_0000, 4'h6);
      @(negedge clk);
      check("mid_pending_valid", {31'd0, bus.out_valid}, 32'd1);
      check("mid_rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("mid_rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mid_after_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_after_ready0", {31'd0, bus.req0_ready}, 32'd1);
      check("mid_after_ready1", {31'd0, bus.req1_ready}, 32'd0);
      tick();
      idle();
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("mid_result", bus.out_result, 32'h0000_0010);
      check("mid_src", {31'd0, bus.out_src}, 32'd0);
      tick();

      // rdy_in low: everything holds, including the round-robin pointer
      set_req(0, SH_SRA, 32'h8000_0000, 32'h0000_0001, 4'hB);
      @(negedge clk);
      check("stall_setup_ready0", {31'd0, bus.req0_ready}, 32'd1);
      tick();
      rdy = 1'b0;
      set_req(0, SH_SLL, 32'h0000_0001, 32'h0000_0001, 4'h2);
      set_req(1, SH_SRL, 32'h0000_00F0, 32'h0000_0004, 4'h6);
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         check($sformatf("stall%0d_ready0", j), {31'd0, bus.req0_ready}, 32'd0);
         check($sformatf("stall%0d_ready1", j), {31'd0, bus.req1_ready}, 32'd0);
         check($sformatf("stall%0d_valid", j), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("stall%0d_result", j), bus.out_result, 32'hC000_0000);
         check($sformatf("stall%0d_tag", j), {28'd0, bus.out_tag}, 32'hB);
         tick();
      end
      rdy = 1'b1;
      @(negedge clk);
      check("resume_ready0", {31'd0, bus.req0_ready}, 32'd0);
      check("resume_ready1", {31'd0, bus.req1_ready}, 32'd1);
      tick();
      idle();
      @(negedge clk);
      check("resume_valid", {31'd0, bus.out_valid}, 32'd1);
      check("resume_result", bus.out_result, 32'h0000_000F);
      check("resume_src", {31'd0, bus.out_src}, 32'd1);
      check("resume_tag", {28'd0, bus.out_tag}, 32'h6);
      tick();
      @(negedge clk);
      check("resume_drained", {31'd0, bus.out_valid}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
